// File: rtl/axis_pulse_step_averager_pkg.sv
// Shared constants for the pulse step averager: FSM codes, upstream status
// word layout and output record layout.
`timescale 1ns/1ps
package axis_pulse_step_averager_pkg;

  // Default field widths
  localparam int STEP_W = 7;
  localparam int RES_W  = 25;
  localparam int ACC_W  = 40;
  localparam int CNT_W  = 16;

  // Upstream status word: {step, result}; the pulse-pattern stage uses the same layout
  localparam int IN_RES_LSB  = 0;
  localparam int IN_STEP_LSB = 25;

  // Output record: {1'b0, step, cnt, acc}
  localparam int REC_ACC_LSB  = 0;
  localparam int REC_CNT_LSB  = 40;
  localparam int REC_STEP_LSB = 56;

  // FSM state codes, also reported in sts_data[31:29]
  typedef logic [2:0] state_t;
  localparam state_t ST_CLEAR = 3'd0;
  localparam state_t ST_ACCUM = 3'd1;
  localparam state_t ST_DRAIN = 3'd2;
  localparam state_t ST_DUMP  = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

endpackage

// File: rtl/axis_pulse_step_averager_ram.sv
// Simple dual-port RAM: one write port, one registered read port, read-first.
`timescale 1ns/1ps
module pulse_step_ram #(
  parameter int AW = 7,
  parameter int DW = 56
) (
  input  logic          i_clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data
);

  logic [DW-1:0] r_mem [2**AW];

  // Write and registered read; a same-address read returns the old contents
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/axis_pulse_step_averager.sv
// Per-step accumulator of upstream pulse results; dumps one record per step
// (0..max step seen) once the upstream sweeps are done.
`timescale 1ns/1ps
module axis_pulse_step_averager
  import axis_pulse_step_averager_pkg::*;
#(
  parameter int STEP_WIDTH = STEP_W,
  parameter int RES_WIDTH  = RES_W,
  parameter int ACC_WIDTH  = ACC_W,
  parameter int CNT_WIDTH  = CNT_W
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        done_flag,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic [31:0] sts_data
);

  localparam int DW = ACC_WIDTH + CNT_WIDTH;

  // Control
  state_t                r_state;
  logic [STEP_WIDTH-1:0] r_clr_addr;
  logic [STEP_WIDTH-1:0] r_max_step;
  logic [15:0]           r_words;
  logic                  r_tready;

  // Read-modify-write pipeline and write-forwarding register
  logic                  r_s1_valid;
  logic [STEP_WIDTH-1:0] r_s1_step;
  logic [RES_WIDTH-1:0]  r_s1_res;
  logic                  r_fw_valid;
  logic [STEP_WIDTH-1:0] r_fw_step;
  logic [DW-1:0]         r_fw_data;

  // Dump: read pointer, in-flight read, output register and skid
  logic [STEP_WIDTH-1:0] r_rd_addr;
  logic                  r_rd_done;
  logic                  r_pend;
  logic [STEP_WIDTH-1:0] r_pend_step;
  logic                  r_o_valid, r_o_last;
  logic [STEP_WIDTH-1:0] r_o_step;
  logic [DW-1:0]         r_o_word;
  logic                  r_s_valid, r_s_last;
  logic [STEP_WIDTH-1:0] r_s_step;
  logic [DW-1:0]         r_s_word;

  logic                  w_xfer;
  logic [STEP_WIDTH-1:0] w_in_step;
  logic [RES_WIDTH-1:0]  w_in_res;
  logic [DW-1:0]         w_ram_rd_data;
  logic [DW-1:0]         w_old;
  logic [ACC_WIDTH-1:0]  w_old_acc, w_new_acc;
  logic [CNT_WIDTH-1:0]  w_old_cnt, w_new_cnt;
  logic                  w_wr_en, w_rd_en;
  logic [STEP_WIDTH-1:0] w_wr_addr, w_rd_addr;
  logic [DW-1:0]         w_wr_data;
  logic                  w_pop, w_issue, w_in_last;
  logic [1:0]            w_occ_next;
  logic [63:0]           w_rec;

  assign w_in_step = s_axis_tdata[IN_STEP_LSB +: STEP_WIDTH];
  assign w_in_res  = s_axis_tdata[IN_RES_LSB +: RES_WIDTH];
  assign w_xfer    = s_axis_tvalid & r_tready;

  // A word right behind a same-step word must see that word's write, which the RAM has not yet committed
  assign w_old     = (r_fw_valid && (r_fw_step == r_s1_step)) ? r_fw_data : w_ram_rd_data;
  assign w_old_acc = w_old[ACC_WIDTH-1:0];
  assign w_old_cnt = w_old[DW-1:ACC_WIDTH];
  assign w_new_acc = w_old_acc + {{(ACC_WIDTH-RES_WIDTH){r_s1_res[RES_WIDTH-1]}}, r_s1_res};
  assign w_new_cnt = (&w_old_cnt) ? w_old_cnt : w_old_cnt + CNT_WIDTH'(1);

  assign w_wr_en   = (r_state == ST_CLEAR) | r_s1_valid;
  assign w_wr_addr = (r_state == ST_CLEAR) ? r_clr_addr : r_s1_step;
  assign w_wr_data = (r_state == ST_CLEAR) ? '0 : {w_new_cnt, w_new_acc};
  assign w_rd_en   = w_xfer | w_issue;
  assign w_rd_addr = (r_state == ST_DUMP) ? r_rd_addr : w_in_step;

  // Only issue a read if the output register plus skid can absorb it next cycle
  assign w_pop      = r_o_valid & m_axis_tready;
  assign w_occ_next = {1'b0, r_o_valid} + {1'b0, r_s_valid} + {1'b0, r_pend} - {1'b0, w_pop};
  assign w_issue    = (r_state == ST_DUMP) && !r_rd_done && (w_occ_next < 2'd2);
  assign w_in_last  = (r_pend_step == r_max_step);

  pulse_step_ram #(
    .AW (STEP_WIDTH),
    .DW (DW)
  ) u_ram (
    .i_clk     (aclk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (w_wr_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_ram_rd_data)
  );

  // Assemble the output record from its field offsets
  always_comb begin
    w_rec = '0;
    w_rec[REC_ACC_LSB +: ACC_WIDTH]   = r_o_word[ACC_WIDTH-1:0];
    w_rec[REC_CNT_LSB +: CNT_WIDTH]   = r_o_word[DW-1:ACC_WIDTH];
    w_rec[REC_STEP_LSB +: STEP_WIDTH] = r_o_step;
  end

  assign s_axis_tready = r_tready;
  assign m_axis_tvalid = r_o_valid;
  assign m_axis_tlast  = r_o_valid & r_o_last;
  assign m_axis_tdata  = w_rec;
  assign sts_data      = {r_state, 5'b0, 8'(r_max_step), r_words};

  // State machine, clear sweep and input statistics
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state    <= ST_CLEAR;
      r_clr_addr <= '0;
      r_max_step <= '0;
      r_words    <= '0;
      r_tready   <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_clr_addr <= r_clr_addr + STEP_WIDTH'(1);
          if (&r_clr_addr) r_state <= ST_ACCUM;
        end
        ST_ACCUM: begin
          r_tready <= !done_flag;
          if (done_flag && !w_xfer) r_state <= ST_DRAIN;
        end
        ST_DRAIN: if (!r_s1_valid) r_state <= ST_DUMP;
        ST_DUMP:  if (w_pop && r_o_last) r_state <= ST_DONE;
        default:  r_tready <= 1'b0;
      endcase
      if (w_xfer) begin
        r_words <= r_words + 16'd1;
        if (w_in_step > r_max_step) r_max_step <= w_in_step;
      end
    end
  end

  // Pipeline valid bits
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_s1_valid <= 1'b0;
      r_fw_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_xfer;
      r_fw_valid <= r_s1_valid;
    end
  end

  // Pipeline payload: captured word and last write for forwarding
  always_ff @(posedge aclk) begin
    r_s1_step <= w_in_step;
    r_s1_res  <= w_in_res;
    r_fw_step <= r_s1_step;
    r_fw_data <= {w_new_cnt, w_new_acc};
  end

  // Dump read sequencing with output register and one-entry skid
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_rd_addr <= '0;
      r_rd_done <= 1'b0;
      r_pend    <= 1'b0;
      r_o_valid <= 1'b0;
      r_o_last  <= 1'b0;
      r_s_valid <= 1'b0;
    end else begin
      r_pend      <= w_issue;
      r_pend_step <= r_rd_addr;
      if (w_issue) begin
        r_rd_addr <= r_rd_addr + STEP_WIDTH'(1);
        if (r_rd_addr == r_max_step) r_rd_done <= 1'b1;
      end
      if (!r_o_valid || w_pop) begin
        if (r_s_valid) begin
          r_o_valid <= 1'b1;
          r_o_last  <= r_s_last;
          r_o_step  <= r_s_step;
          r_o_word  <= r_s_word;
          r_s_valid <= r_pend;
          r_s_last  <= w_in_last;
          r_s_step  <= r_pend_step;
          r_s_word  <= w_ram_rd_data;
        end else begin
          r_o_valid <= r_pend;
          r_o_last  <= w_in_last;
          r_o_step  <= r_pend_step;
          r_o_word  <= w_ram_rd_data;
        end
      end else if (r_pend) begin
        r_s_valid <= 1'b1;
        r_s_last  <= w_in_last;
        r_s_step  <= r_pend_step;
        r_s_word  <= w_ram_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_axis_pulse_step_averager.sv
// Directed bench for axis_pulse_step_averager.
`timescale 1ns/1ps
module tb_axis_pulse_step_averager;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        done_flag;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [31:0] sts_data;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q [$];

  always #5 aclk = ~aclk;

  axis_pulse_step_averager dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .done_flag     (done_flag),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .sts_data      (sts_data)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] rec(input int step, input int cnt, input longint acc);
    logic [6:0]  s;
    logic [15:0] c;
    logic [39:0] a;
    s = step[6:0];
    c = cnt[15:0];
    a = acc[39:0];
    return {1'b0, s, c, a};
  endfunction

  function automatic logic [63:0] sts(input int st, input int mx, input int w);
    logic [2:0]  s;
    logic [7:0]  m;
    logic [15:0] n;
    s = st[2:0];
    m = mx[7:0];
    n = w[15:0];
    return {32'd0, s, 5'd0, m, n};
  endfunction

  task automatic start_reset();
    aresetn       = 1'b0;
    done_flag     = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  task automatic wait_accum();
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (s_axis_tready) ok = 1;
      else begin
        @(posedge aclk);
        #1;
      end
    end
    if (!ok) check("accum_timeout", 64'(s_axis_tready), 64'd1);
  endtask

  // One beat; consecutive calls keep tvalid high for full-rate streaming
  task automatic send(input int step, input int res, input bit done);
    logic [6:0]  s;
    logic [24:0] r;
    s = step[6:0];
    r = res[24:0];
    s_axis_tdata  = {s, r};
    s_axis_tvalid = 1'b1;
    done_flag     = done;
    $display("send step=%0d res=%0d done=%0b", step, res, done);
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  // Receive the dump, checking order, content, tlast and stability under backpressure
  task automatic collect(input bit rnd, input int abort_after);
    int          idx = 0;
    int          gaps = 0;
    bit          seen = 0;
    bit          prev_stall = 0;
    bit          fin = 0;
    logic [63:0] prev_data = '0;
    m_axis_tready = rnd ? 1'($urandom % 2) : 1'b1;
    for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
      @(negedge aclk);
      if (prev_stall) begin
        check("stall_valid", 64'(m_axis_tvalid), 64'd1);
        check("stall_data", m_axis_tdata, prev_data);
      end
      if (seen && !m_axis_tvalid && !rnd) gaps++;
      if (m_axis_tvalid) seen = 1;
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      if (m_axis_tvalid && m_axis_tready) begin
        $display("record %0d: step=%0d cnt=%0d acc=%h last=%0b", idx,
                 m_axis_tdata[62:56], m_axis_tdata[55:40], m_axis_tdata[39:0], m_axis_tlast);
        check("rec_data", m_axis_tdata, exp_q[idx]);
        check("rec_last", 64'(m_axis_tlast), 64'(idx == exp_q.size() - 1));
        idx++;
        if (idx == exp_q.size()) fin = 1;
        if (abort_after != 0 && idx == abort_after) fin = 1;
      end
      @(posedge aclk);
      #1;
      if (rnd) m_axis_tready = 1'($urandom % 2);
    end
    check("rec_count", 64'(idx), 64'(abort_after != 0 ? abort_after : exp_q.size()));
    if (!rnd) check("no_gaps", 64'(gaps), 64'd0);
  endtask

  initial begin
    int m_activity;

    // Reset values
    aresetn       = 1'b0;
    done_flag     = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_sts", 64'(sts_data), 64'd0);
    check("rst_s_tready", 64'(s_axis_tready), 64'd0);
    check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
    aresetn = 1'b1;

    // CLEAR sweep timing
    m_activity = 0;
    for (int k = 1; k <= 130; k++) begin
      @(posedge aclk);
      #1;
      if (m_axis_tvalid) m_activity++;
      if (k == 127) begin
        check("clear_state_127", 64'(sts_data[31:29]), 64'd0);
        check("clear_tready_127", 64'(s_axis_tready), 64'd0);
      end
      if (k == 128) begin
        check("accum_state_128", 64'(sts_data[31:29]), 64'd1);
        check("tready_128", 64'(s_axis_tready), 64'd0);
      end
      if (k == 129) check("tready_129", 64'(s_axis_tready), 64'd1);
    end
    check("clear_no_m_activity", 64'(m_activity), 64'd0);

    // Four sweeps of steps 1..3
    for (int sw = 0; sw < 4; sw++) begin
      send(1, 100, 0);
      send(2, -50, 0);
      send(3, 7, 0);
    end
    done_flag = 1'b1;
    exp_q = '{rec(0, 0, 0), rec(1, 4, 400), rec(2, 4, -200), rec(3, 4, 28)};
    collect(0, 0);
    check("a_done_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("a_done_sts", 64'(sts_data), sts(4, 3, 12));

    // Same-step burst at full rate, final word with done_flag, random backpressure
    start_reset();
    wait_accum();
    for (int i = 0; i < 8; i++) send(5, -1, 0);
    send(2, 1, 1);
    check("b_tready_after_done", 64'(s_axis_tready), 64'd0);
    exp_q = '{rec(0, 0, 0), rec(1, 0, 0), rec(2, 1, 1), rec(3, 0, 0), rec(4, 0, 0), rec(5, 8, -8)};
    collect(1, 0);
    check("b_done_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("b_done_sts", 64'(sts_data), sts(4, 5, 9));

    // Reset mid-dump after two records, then a fresh run
    start_reset();
    wait_accum();
    send(3, 5, 0);
    send(1, -2, 1);
    exp_q = '{rec(0, 0, 0), rec(1, 1, -2), rec(2, 0, 0), rec(3, 1, 5)};
    collect(0, 2);
    aresetn = 1'b0;
    @(posedge aclk);
    #1;
    check("c_abort_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("c_abort_tlast", 64'(m_axis_tlast), 64'd0);
    check("c_abort_sts", 64'(sts_data), 64'd0);
    done_flag = 1'b0;
    aresetn   = 1'b1;
    wait_accum();
    send(2, 9, 1);
    exp_q = '{rec(0, 0, 0), rec(1, 0, 0), rec(2, 1, 9)};
    collect(0, 0);
    check("c_done_sts", 64'(sts_data), sts(4, 2, 1));

    // Single-entry dump: tvalid and tlast together
    start_reset();
    wait_accum();
    send(0, 3, 1);
    exp_q = '{rec(0, 1, 3)};
    collect(0, 0);
    check("d_done_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("d_done_sts", 64'(sts_data), sts(4, 0, 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_pulse_step_averager.md
Name: axis_pulse_step_averager

Overview:
Sits directly downstream of the pulse-pattern stage and consumes its 32-bit per-pulse status stream ({step[6:0], result[24:0]}). Accumulates a signed result sum and a hit count per pattern step across all sweeps, using an internal RAM indexed by step. When the upstream stage reports completion, it streams out one 64-bit record per step (0..max step seen) to a DMA/FIFO stage.

Parameters:
STEP_WIDTH, 7, width of step field in s_axis_tdata[31:25]; RAM depth 2**STEP_WIDTH
RES_WIDTH, 25, width of signed result field s_axis_tdata[24:0]
ACC_WIDTH, 40, signed accumulator width per step
CNT_WIDTH, 16, per-step hit counter width

Ports:
aclk  in  1  clock
aresetn  in  1  reset: synchronous, active-low
done_flag  in  1  upstream sweeps finished (upstream case_id==5); level
s_axis_tdata  in  32  {step, result} from upstream status port
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
m_axis_tdata  out  64  {1'b0, step[6:0], cnt[15:0], acc[39:0]}
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  last record of dump
sts_data  out  32  {state[2:0], 5'b0, max_step[7:0], words_accepted[15:0]}

Behaviour:
- Reset (aresetn low at posedge): state=CLEAR, clear address 0, max_step=0, words_accepted=0, s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, pipeline valid=0. Reset mid-dump aborts the dump immediately; no partial record is held.
- States: CLEAR -> ACCUM -> DRAIN -> DUMP -> DONE.
- CLEAR: one RAM entry zeroed per cycle, addresses 0..2**STEP_WIDTH-1 (128 cycles default); then ACCUM. tready=0.
- ACCUM: s_axis_tready=1. Transfer = tvalid&tready. Two-stage RMW: cycle N captures word, issues RAM read at step. Cycle N+1 adds sign-extended result (RES_WIDTH->ACC_WIDTH, wraps modulo 2**ACC_WIDTH) and cnt+1 (saturates at all-ones), then writes back.
- Hazard: if the word in stage 1 has the same step as the stage-1 write in flight, stage 1 uses the forwarded write data, not RAM output. Back-to-back same-step words at full rate must be counted exactly.
- max_step updates to step when step > max_step. words_accepted increments per transfer, wraps at 2**16.
- ACCUM -> DRAIN when done_flag=1 and no transfer occurs that cycle; tready drops the same cycle. A word transferred in the cycle done_flag rises is still accumulated.
- DRAIN: waits until the RMW pipeline is empty (≤2 cycles), then enters DUMP at address 0.
- DUMP: reads entries 0..max_step in order via a 1-deep output register plus 1-entry skid, so throughput is 1 record/cycle with tready held high.
- Data and tvalid stay stable while tvalid&~tready. tlast=1 only on the record for max_step.
- DUMP -> DONE after the tlast handshake. A single-entry dump (max_step=0) asserts tvalid and tlast together.
- DONE: tready=0, tvalid=0; holds until reset. done_flag is ignored outside ACCUM.
- Output record: acc in [39:0], cnt in [55:40], step in [62:56], bit 63=0.
- State encoding in sts_data: CLEAR=0, ACCUM=1, DRAIN=2, DUMP=3, DONE=4.

Decomposition:
- Shared package: state enum (3-bit codes above), record field offsets, and the STEP/RES field positions of the upstream status word. The upstream stage uses the same field positions.
- One sub-module: pulse_step_ram, a simple dual-port RAM (1 write port, 1 read port, 1-cycle registered read, width ACC_WIDTH+CNT_WIDTH, read-first). Forwarding logic stays in the top.

Test Plan:
- Reset, then idle 130 cycles -> sts state goes CLEAR->ACCUM at cycle 128; s_axis_tready asserts at cycle 129; no m_axis activity.
- Send steps 1,2,3 with results +100,-50,+7, repeated 4 sweeps, then done_flag -> 4 records (steps 0..3). Required (step, cnt, acc): (0,0,0), (1,4,400), (2,4,-200 sign-extended), (3,4,28). tlast on step 3 only.
- Eight consecutive transfers, all step 5, result 25'h1FFFFFF (-1), full rate -> step-5 record shows cnt=8, acc=-8; forwarding verified.
- Random m_axis_tready (50%) during dump -> tdata never changes while tvalid&~tready; records arrive in order with no gaps or duplicates.
- done_flag asserted in the same cycle as a final step-2 transfer of +1 -> that +1 is included; tready=0 from the next cycle.
- Assert aresetn low mid-DUMP after 2 records -> next cycle tvalid=0. After reset, CLEAR runs, and a fresh dump shows all-zero counts except new input.
